// File: rtl/flick_conditioner.sv
// flick_conditioner
//   Turns a raw, bouncing push-button into a clean, fixed-length "flick"
//   request for the flasher. The chain is:
//     2-flop synchronizer -> debounce counter -> rise detector -> hold FSM.
//   The hold FSM stretches each accepted press to HOLD_CYCLES cycles. The
//   downstream ack can cut the hold short. The FSM then waits for the
//   debounced button to be released before it will accept another press.
//
// Parameters
//   DB_CYCLES    consecutive synchronized samples needed to accept a level
//                change (1..255)
//   HOLD_CYCLES  flick high time per accepted press, in cycles (1..255)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous reset, active-low
//   btn_in     raw asynchronous button level, active-high
//   ack        downstream consumed the request; only honoured during a hold
//   flick      stretched press request (registered)
//   btn_level  debounced button level (registered)
//   btn_rise   one-cycle pulse after the debounced 0->1 edge (registered)
//   busy       high whenever the FSM is not idle (registered)
module flick_conditioner #(
   parameter int DB_CYCLES   = 4,
   parameter int HOLD_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   input  logic ack,
   output logic flick,
   output logic btn_level,
   output logic btn_rise,
   output logic busy
);

   localparam logic [7:0] DB_MAX    = 8'(DB_CYCLES - 1);
   localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, HOLD, WAIT_REL} state_t;

   logic       s_meta, s_sync;
   logic [7:0] db_cnt, hold_cnt;
   state_t     state;
   logic       db_flip, rise_now;

   // db_flip marks the edge at which btn_level will toggle. The FSM must
   // react on that same edge, so it watches this term and not the
   // registered btn_level.
   assign db_flip  = (s_sync != btn_level) && (db_cnt == DB_MAX);
   assign rise_now = db_flip && !btn_level;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_meta <= 1'b0;
         s_sync <= 1'b0;
      end else begin
         s_meta <= btn_in;
         s_sync <= s_meta;
      end
   end

   // The counter runs only while the synchronized input disagrees with the
   // accepted level. Any agreeing sample restarts the count, so a bounce
   // that is shorter than DB_CYCLES samples never reaches the toggle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         db_cnt    <= 8'd0;
         btn_level <= 1'b0;
         btn_rise  <= 1'b0;
      end else begin
         btn_rise <= rise_now;
         if (s_sync == btn_level) begin
            db_cnt <= 8'd0;
         end else if (db_cnt == DB_MAX) begin
            db_cnt    <= 8'd0;
            btn_level <= ~btn_level;
         end else begin
            db_cnt <= db_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         hold_cnt <= 8'd0;
         flick    <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (rise_now) begin
                  state    <= HOLD;
                  hold_cnt <= HOLD_LOAD;
                  flick    <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            HOLD: begin
               // ack has priority over counter expiry. Releasing the button
               // does not shorten the hold.
               if (ack || hold_cnt == 8'd0) begin
                  state    <= WAIT_REL;
                  hold_cnt <= 8'd0;
                  flick    <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt - 8'd1;
               end
            end
            WAIT_REL: begin
               if (!btn_level) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               hold_cnt <= 8'd0;
               flick    <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_flick_conditioner.sv
// Scoreboard bench for flick_conditioner (default parameters).
//
// The driver applies inputs just after each rising edge. It steps a
// behavioural model and pushes the outputs it expects to see at the
// following falling edge. A separate monitor pops one entry per falling
// edge and compares it against the DUT outputs.
//
// The model describes behaviour, not the RTL structure:
//   - the synchronizer is a two-deep delay;
//   - debounce accepts a new level once the last DB synchronized samples
//     all differ from the current level;
//   - the hold is a count of remaining flick cycles plus a
//     "waiting for release" flag.
module tb_flick_conditioner;
   localparam int DB   = 4;
   localparam int HOLD = 16;

   logic clk = 1'b0;
   logic rst, btn_in, ack;
   logic flick, btn_level, btn_rise, busy;

   flick_conditioner #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD)) dut (
      .clk(clk), .rst(rst), .btn_in(btn_in), .ack(ack),
      .flick(flick), .btn_level(btn_level), .btn_rise(btn_rise), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic flick;
      logic level;
      logic rise;
      logic busy;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Behavioural reference model state.
   bit m_s0, m_s1;
   bit hist[$];
   bit m_lvl, m_rise, m_wait;
   int m_hold;

   task automatic model_reset();
      m_s0 = 0; m_s1 = 0; hist.delete();
      m_lvl = 0; m_rise = 0; m_wait = 0; m_hold = 0;
   endtask

   // One rising edge, using the inputs that were present at that edge.
   task automatic model_step(input bit b, input bit a);
      bit all_diff, new_lvl, rise;
      hist.push_back(m_s1);
      if (hist.size() > DB) void'(hist.pop_front());
      all_diff = (hist.size() == DB);
      foreach (hist[i]) if (hist[i] == m_lvl) all_diff = 0;
      new_lvl = all_diff ? !m_lvl : m_lvl;
      if (all_diff) hist.delete();
      rise = new_lvl && !m_lvl;
      if (m_hold > 0) begin
         if (a) m_hold = 0;
         else m_hold = m_hold - 1;
         if (m_hold == 0) m_wait = 1;
      end else if (m_wait) begin
         if (!m_lvl) m_wait = 0;
      end else if (rise) begin
         m_hold = HOLD;
      end
      m_lvl = new_lvl; m_rise = rise;
      m_s1 = m_s0; m_s0 = b;
   endtask

   // One cycle of stimulus: advance the model past the edge, apply the new
   // inputs, and queue the outputs expected at the next falling edge.
   task automatic cyc(input logic b, input logic a, input logic r);
      exp_t e;
      @(posedge clk);
      if (rst) model_step(btn_in, ack);
      #1;
      btn_in = b; ack = a; rst = r;
      if (!r) model_reset();   // asynchronous: outputs clear before the next edge
      e.flick = (m_hold > 0);
      e.level = m_lvl;
      e.rise  = m_rise;
      e.busy  = (m_hold > 0) || m_wait;
      exp_q.push_back(e);
   endtask

   task automatic run(input logic b, input logic a, input logic r, input int n);
      for (int i = 0; i < n; i++) cyc(b, a, r);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks += 4;
         if (flick !== e.flick) begin
            errors++;
            $display("FAIL flick t=%0t got %b exp %b", $time, flick, e.flick);
         end
         if (btn_level !== e.level) begin
            errors++;
            $display("FAIL btn_level t=%0t got %b exp %b", $time, btn_level, e.level);
         end
         if (btn_rise !== e.rise) begin
            errors++;
            $display("FAIL btn_rise t=%0t got %b exp %b", $time, btn_rise, e.rise);
         end
         if (busy !== e.busy) begin
            errors++;
            $display("FAIL busy t=%0t got %b exp %b", $time, busy, e.busy);
         end
      end
   end

   initial begin
      int flick_seen;
      rst = 1'b0; btn_in = 1'b0; ack = 1'b0;
      model_reset();

      // Reset held while btn_in toggles.
      for (int i = 0; i < 8; i++) cyc(1'(i & 1), 1'b0, 1'b0);

      // Release reset with btn_in already high: this is a fresh press.
      run(1, 0, 1, 40);
      run(0, 0, 1, 30);

      // Clean press followed by release.
      run(1, 0, 1, 40);
      run(0, 0, 1, 20);

      // Bounce that is too short to be accepted.
      run(1, 0, 1, 3); run(0, 0, 1, 2); run(1, 0, 1, 2); run(0, 0, 1, 20);

      // Early ack in the cycle after the 5th flick edge; later acks must
      // be ignored.
      run(1, 0, 1, 10); run(1, 1, 1, 1); run(1, 0, 1, 10);
      run(1, 1, 1, 1); run(1, 0, 1, 10);
      run(0, 1, 1, 1); run(0, 0, 1, 20);

      // Short press, then a second press 20 cycles later.
      run(1, 0, 1, 8); run(0, 0, 1, 20);
      run(1, 0, 1, 8); run(0, 0, 1, 30);

      // Reset between edges during the 3rd flick cycle, released with
      // btn_in low.
      run(1, 0, 1, 8); run(1, 0, 0, 2); run(0, 0, 0, 1); run(0, 0, 1, 30);

      // Randomized runs with random lengths, sparse acks and occasional
      // resets.
      begin
         logic b;
         b = 1'b0;
         for (int k = 0; k < 150; k++) begin
            int len;
            b   = ~b;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                              : $urandom_range(4, 30);
            for (int j = 0; j < len; j++)
               cyc(b, 1'($urandom_range(0, 15) == 0),
                   1'($urandom_range(0, 299) != 0));
         end
         run(0, 0, 1, 40);
      end

      // Sanity: confirm that some flick activity actually reached the
      // monitor.
      flick_seen = 0;
      repeat (2) begin
         run(1, 0, 1, 12);
         if (flick) flick_seen++;
         run(0, 0, 1, 30);
      end
      checks++;
      if (flick_seen != 2) begin
         errors++;
         $display("FAIL flick_activity got %0d exp 2", flick_seen);
      end

      // Drain the queue, with a bounded wait.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain left %0d exp 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/flick_conditioner.md
FLICK_CONDITIONER -- requirements
Module: flick_conditioner

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 4, consecutive synchronized samples needed to accept a level change; legal range 1..255.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, cycles the flick output is held per accepted press; legal range 1..255.
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port btn_in  input  1  raw, asynchronous, bouncing push-button level, active-high.
REQ-006 SHALL have port ack  input  1  downstream consumed the request, synchronous to clk.
REQ-007 SHALL have port flick  output  1  stretched press request driven to the flasher flick input.
REQ-008 SHALL have port btn_level  output  1  debounced button level.
REQ-009 SHALL have port btn_rise  output  1  one-cycle pulse on debounced rising edge.
REQ-010 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-011 SHALL pass btn_in through a 2-flop synchronizer; synchronized value (s_sync) is valid after the 2nd edge following a btn_in change.
REQ-012 SHALL keep an 8-bit debounce counter: at each edge, s_sync == btn_level -> counter cleared; s_sync != btn_level and counter < DB_CYCLES-1 -> counter +1; s_sync != btn_level and counter == DB_CYCLES-1 -> btn_level toggles, counter cleared.
REQ-013 SHALL therefore update btn_level at edge 2+DB_CYCLES after a stable btn_in change (edge 6 at defaults); any bounce shorter than DB_CYCLES synchronized samples SHALL leave btn_level unchanged.
REQ-014 SHALL register btn_rise high for exactly the one cycle following the edge at which btn_level goes 0->1; no pulse on 1->0.
REQ-015 SHALL implement FSM states IDLE, HOLD, WAIT_REL.
REQ-016 IDLE: on the edge where btn_level goes 0->1 SHALL enter HOLD, load hold counter with HOLD_CYCLES-1, assert flick from that edge.
REQ-017 HOLD: each edge SHALL decrement hold counter; edge with counter == 0 SHALL go WAIT_REL and deassert flick, giving exactly HOLD_CYCLES cycles of flick high.
REQ-018 HOLD: ack high at an edge SHALL go WAIT_REL and deassert flick at that edge, taking priority over counter expiry.
REQ-019 WAIT_REL: SHALL keep flick low; SHALL go IDLE at the first edge where btn_level is 0.
REQ-020 ack outside HOLD SHALL be ignored; btn_rise outside IDLE SHALL NOT start a new hold (btn_rise still pulses).
REQ-021 Button released (btn_level falls) during HOLD SHALL NOT shorten the hold; FSM passes through WAIT_REL to IDLE one edge after hold ends.
REQ-022 flick, btn_level, btn_rise, busy SHALL be registered outputs with no combinational path from btn_in or ack.
REQ-023 busy SHALL be 1 in HOLD and WAIT_REL, 0 in IDLE.

Reset
REQ-024 rst low SHALL immediately force flick=0, btn_level=0, btn_rise=0, busy=0, FSM=IDLE, synchronizer flops, debounce and hold counters to 0, regardless of clk.
REQ-025 On rst release with btn_in already high, SHALL treat it as a fresh press: flick asserts at edge 2+DB_CYCLES after release.
REQ-026 Reset asserted mid-HOLD SHALL abort the hold with no further flick cycles after release unless a new debounced press occurs.

Verification
REQ-027 Reset: rst=0 with btn_in toggling -> all outputs 0 throughout; release rst, btn_in held high -> btn_level, btn_rise, flick rise after edge 6.
REQ-028 Clean press: btn_in high at edge 0 held 40 cycles -> btn_rise high only in cycle after edge 6; flick high after edges 6..21 (16 cycles), low after edge 22; busy high until btn_level low after release +6 edges.
REQ-029 Bounce: btn_in high 3 cycles, low 2, high 2, low -> btn_level, btn_rise, flick never assert; debounce counter returns to 0.
REQ-030 Early ack: clean press, ack high one cycle at 5th flick cycle -> flick low after that edge (5 cycles total); later acks ignored; no re-trigger until release and re-press.
REQ-031 Short press: btn_in high 8 cycles then low -> flick still 16 cycles; busy drops one edge after flick; second press 20 cycles later -> new 16-cycle flick.
REQ-032 Reset mid-hold: rst=0 at 3rd flick cycle between edges -> flick drops without clock edge; release rst with btn_in low -> flick stays 0.
